pipe_hazard_unit: RTL
=====================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MEM_LAT, default 1, legal 1..8, total M-stage cycles per data-memory access.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have ports rs1D, rs2D, rs1E, rs2E  in  REG_AW each  source register addresses in the D and E stages.
REQ-006 SHALL have ports writeregE, writeregM, writeregW  in  REG_AW each  destination register addresses in the E, M and W stages.
REQ-007 SHALL have ports regwriteE, regwriteM, regwriteW, memtoregE, memtoregM  in  1 each  stage write and load flags.
REQ-008 SHALL have ports branchD, jumpD, pcsrcD, memreqM  in  1 each  branch in D, jump in D, redirect taken, memory access in M.
REQ-009 SHALL have ports forwardAE, forwardBE  out  2 each  E-stage operand mux selects: 00 = register file, 01 = resultW, 10 = aluoutM.
REQ-010 SHALL have ports forwardAD, forwardBD  out  1 each  D-stage branch-compare forward from aluoutM.
REQ-011 SHALL have ports stallF, stallD, stallE, stallM, flushD, flushE, flushW  out  1 each  pipeline-register control.
REQ-012 SHALL have ports stall_cnt, flush_cnt  out  16 each  statistics counters.

Function
REQ-013 forwardAE SHALL be 10 if rs1E!=0, regwriteM=1 and writeregM==rs1E; otherwise 01 if rs1E!=0, regwriteW=1 and writeregW==rs1E; otherwise 00. forwardBE SHALL follow the same rule using rs2E. M-stage priority SHALL win over W.
REQ-014 forwardAD and forwardBD SHALL be 1 iff rsXD!=0, regwriteM=1 and writeregM==rsXD.
REQ-015 lwstall SHALL be 1 iff memtoregE=1 and writeregE!=0 and writeregE equals rs1D or rs2D.
REQ-016 brstall SHALL be 1 iff branchD=1 and either:
- regwriteE=1 and writeregE matches a nonzero rs1D or rs2D; or
- memtoregM=1 and writeregM matches a nonzero rs1D or rs2D.
REQ-017 The memory-wait FSM SHALL have states IDLE and WAIT, plus a 3-bit counter cnt.
REQ-018 In IDLE with memreqM=1 and MEM_LAT>1, memstall SHALL be 1, cnt SHALL load 1, and next state SHALL be WAIT.
REQ-019 In IDLE with MEM_LAT=1, memstall SHALL never be asserted.
REQ-020 In WAIT, memstall SHALL be 1 while cnt<MEM_LAT-1 and cnt SHALL increment. When cnt==MEM_LAT-1, memstall SHALL be 0 and next state SHALL be IDLE. An access SHALL therefore stall exactly MEM_LAT-1 cycles.
REQ-021 When memstall=1:
- stallF, stallD, stallE, stallM and flushW SHALL be 1.
- flushD and flushE SHALL be 0.
REQ-022 When memstall=0:
- stallF = stallD = lwstall|brstall.
- flushE = lwstall|brstall.
- stallE = stallM = flushW = 0.
REQ-023 flushD SHALL be (pcsrcD|jumpD) & ~stallD. A redirect that coincides with a stall SHALL be deferred.
REQ-024 Back-to-back accesses (memreqM=1 in the release cycle's successor) SHALL start a new IDLE→WAIT sequence with no extra bubble.
REQ-025 All outputs except the counters SHALL be combinational from the inputs and FSM state.

Reset
REQ-026 Asserting reset (low) SHALL immediately set state=IDLE and cnt=0, and SHALL clear stall_cnt and flush_cnt, including mid-WAIT.
REQ-027 On the first edge after reset is released, the FSM SHALL evaluate from IDLE.

Configuration
REQ-028 With macro HAZARD_STATS_EN defined:
- stall_cnt SHALL increment, saturating at 16'hFFFF, every cycle stallF=1.
- flush_cnt SHALL do likewise every cycle flushD|flushE=1.
REQ-029 Without HAZARD_STATS_EN, stall_cnt and flush_cnt SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-030 A shared package pipe_pkg SHALL hold:
- the 2-bit forward-select typedef fwd_sel_t with constants FWD_RF=00, FWD_W=01, FWD_M=10;
- the FSM state enum;
- the statistics width constant STAT_W=16.
REQ-031 A sub-module sat_counter (width parameter, enable, async active-low clear) SHALL implement each statistics counter.

Verification
REQ-032 E-stage forwarding with no stalls:
- Stimulus: regwriteM=1, writeregM=3, regwriteW=1, writeregW=3, rs1E=3, rs2E=0.
- Required: forwardAE=10, forwardBE=00, no stalls.
REQ-033 Load-use hazard:
- Stimulus: memtoregE=1, writeregE=5, rs2D=5.
- Required: stallF=stallD=flushE=1, flushD=0, for one cycle.
REQ-034 Memory wait at MEM_LAT=3:
- Stimulus: memreqM=1 held for 3 cycles.
- Required: stallF..stallM=1 and flushW=1 for exactly 2 cycles, then 0.
- With HAZARD_STATS_EN: stall_cnt=2 afterwards.
REQ-035 Deferred redirect:
- Stimulus: pcsrcD=1 with brstall=1 (regwriteE=1, writeregE=rs1D=7).
- Required: flushD=0 that cycle; flushD=1 the next cycle once brstall clears.
REQ-036 Reset inside a wait:
- Stimulus: reset driven low while in WAIT at MEM_LAT=4.
- Required: all stalls deassert immediately and counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: forward selects, memory-wait
// FSM states and the statistics counter width.
package pipe_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/pipe_hazard_unit_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clearN,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk or negedge clearN) begin
        if (!clearN) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use / branch stalls,
// multi-cycle memory wait and redirect flushes. Define HAZARD_STATS_EN for counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              jumpD,
    input  logic              pcsrcD,
    input  logic              memreqM,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushW,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    localparam bit         MULTI_CYCLE = (MEM_LAT > 1);
    localparam logic [2:0] CNT_LAST    = 3'(MEM_LAT - 1);

    fwd_sel_t   fwdA;
    fwd_sel_t   fwdB;
    logic       rs1DNz;
    logic       rs2DNz;
    logic       lwStall;
    logic       brStall;
    logic       hazStall;
    logic       memStall;
    mem_state_t state;
    logic [2:0] cnt;

    // E-stage operand forwarding; the younger M-stage result takes priority.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        fwdA = FWD_RF;
        fwdB = FWD_RF;
        if ((rs1E != '0) && regwriteM && (writeregM == rs1E)) begin
            fwdA = FWD_M;
        end else if ((rs1E != '0) && regwriteW && (writeregW == rs1E)) begin
            fwdA = FWD_W;
        end
        if ((rs2E != '0) && regwriteM && (writeregM == rs2E)) begin
            fwdB = FWD_M;
        end else if ((rs2E != '0) && regwriteW && (writeregW == rs2E)) begin
            fwdB = FWD_W;
        end
    end

    assign forwardAE = fwdA;
    assign forwardBE = fwdB;

    assign rs1DNz    = (rs1D != '0);
    assign rs2DNz    = (rs2D != '0);
    assign forwardAD = rs1DNz && regwriteM && (writeregM == rs1D);
    assign forwardBD = rs2DNz && regwriteM && (writeregM == rs2D);

    assign lwStall = memtoregE && (writeregE != '0)
                   && ((writeregE == rs1D) || (writeregE == rs2D));

    // Branch compare in D needs operands an E-stage ALU op or M-stage load has not produced yet.
    assign brStall = branchD
                   && ((regwriteE && ((rs1DNz && (writeregE == rs1D)) ||
                                      (rs2DNz && (writeregE == rs2D))))
                    || (memtoregM && ((rs1DNz && (writeregM == rs1D)) ||
                                      (rs2DNz && (writeregM == rs2D)))));

    assign hazStall = lwStall | brStall;

    always_comb begin
        memStall = 1'b0;
        unique case (state)
            IDLE:    memStall = MULTI_CYCLE && memreqM;
            WAIT:    memStall = (cnt < CNT_LAST);
            default: memStall = 1'b0;
        endcase
    end

    // Memory-wait FSM: an access holds M for MEM_LAT-1 stall cycles, then releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking so state and cnt both update from pre-edge values.
            unique case (state)
                IDLE: begin
                    if (MULTI_CYCLE && memreqM) begin
                        state <= WAIT;
                        cnt   <= 3'd1;
                    end
                end
                WAIT: begin
                    if (cnt < CNT_LAST) begin
                        cnt <= cnt + 3'd1;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign stallF = memStall | hazStall;
    assign stallD = memStall | hazStall;
    assign stallE = memStall;
    assign stallM = memStall;
    assign flushW = memStall;
    assign flushE = ~memStall & hazStall;
    // A redirect during any stall is held off until D is free to advance.
    assign flushD = (pcsrcD | jumpD) & ~stallD;

`ifdef HAZARD_STATS_EN
    sat_counter #(.WIDTH(STAT_W)) uStallCnt (
        .clk    (clk),
        .clearN (reset),
        .en     (stallF),
        .count  (stall_cnt)
    );

    sat_counter #(.WIDTH(STAT_W)) uFlushCnt (
        .clk    (clk),
        .clearN (reset),
        .en     (flushD | flushE),
        .count  (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
